branch_cond_unit: RTL

- Parametrised successor to the single-bit CON flip-flop logic in the datapath branch path.
- Evaluates an IR condition field against one bus value, or against the signed difference of two bus values delivered on consecutive transfers.
- Registers the result as the CON flag with a valid/ack handshake toward the control unit.
- Sits between the bus mux output and the control sequencer's branch-decision state.

---
 rtl/branch_cond_pkg.sv | 23 ++
 rtl/branch_cond_unit_cond_eval.sv | 33 +++
 rtl/branch_cond_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/branch_cond_pkg.sv
// Shared types for the branch condition unit: condition codes, FSM states and the CC field width.
package branch_cond_pkg;

    localparam int CC_W = 3;

    typedef enum logic [2:0] {
        CC_EQ = 3'b000,
        CC_NE = 3'b001,
        CC_PL = 3'b010,
        CC_MI = 3'b011,
        CC_GT = 3'b100,
        CC_LE = 3'b101,
        CC_AL = 3'b110,
        CC_NV = 3'b111
    } cond_code_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT_B = 2'b01,
        RESULT = 2'b10
    } bcu_state_e;

endpackage

// File: rtl/branch_cond_unit_cond_eval.sv
// Combinational condition evaluator: tests a sign-extended (DATA_W+1)-bit value against a condition code.
module cond_eval
    import branch_cond_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic signed [DATA_W:0] value_i,
    input  cond_code_e             cc_i,
    output logic                   taken_o
);

    logic is_zero;
    logic is_neg;

    assign is_zero = (value_i == '0);
    assign is_neg  = value_i[DATA_W];

    always_comb begin
        taken_o = 1'b0;
        unique case (cc_i)
            CC_EQ:   taken_o = is_zero;
            CC_NE:   taken_o = !is_zero;
            CC_PL:   taken_o = !is_neg;
            CC_MI:   taken_o = is_neg;
            CC_GT:   taken_o = !is_neg && !is_zero;
            CC_LE:   taken_o = is_neg || is_zero;
            CC_AL:   taken_o = 1'b1;
            CC_NV:   taken_o = 1'b0;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_cond_unit.sv
// CON flag unit: evaluates a condition on one operand or on A-B, holding the result until acknowledged.
// Optional BRANCH_STATS_EN adds saturating evaluation/taken counters.
module branch_cond_unit
    import branch_cond_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CC_W   = 3,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [CC_W-1:0]   cc_in,
    input  logic              two_op,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              abort,
    output logic              con_out,
    output logic              con_valid,
    input  logic              con_ack,
    output logic              busy
`ifdef BRANCH_STATS_EN
    ,
    output logic [STAT_W-1:0] eval_cnt,
    output logic [STAT_W-1:0] taken_cnt
`endif
);

    bcu_state_e        state_q;
    logic [DATA_W-1:0] opa_q;
    cond_code_e        cc_q;
    logic              con_q;

    logic                   transfer;
    logic                   eval_fire;
    logic signed [DATA_W:0] bus_ext;
    logic signed [DATA_W:0] opa_ext;
    logic signed [DATA_W:0] eval_value_d;
    cond_code_e             eval_cc_d;
    logic                   taken_d;

    assign in_ready  = (state_q != RESULT);
    assign con_valid = (state_q == RESULT);
    assign busy      = (state_q != IDLE);
    assign con_out   = con_q;

    // abort overrides any operand offered in the same cycle
    assign transfer  = in_valid && in_ready && !abort;
    assign eval_fire = transfer && ((state_q == WAIT_B) || (state_q == IDLE && !two_op));

    assign bus_ext = {bus_in[DATA_W-1], bus_in};
    assign opa_ext = {opa_q[DATA_W-1], opa_q};

    // One extra bit on the difference keeps the sign correct when A-B overflows DATA_W
    always_comb begin
        eval_value_d = bus_ext;
        eval_cc_d    = cond_code_e'(cc_in);
        if (state_q == WAIT_B) begin
            eval_value_d = opa_ext - bus_ext;
            eval_cc_d    = cc_q;
        end
    end

    cond_eval #(
        .DATA_W (DATA_W)
    ) u_cond_eval (
        .value_i (eval_value_d),
        .cc_i    (eval_cc_d),
        .taken_o (taken_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            cc_q    <= CC_EQ;
            con_q   <= 1'b0;
        end else if (abort) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (transfer) begin
                        if (two_op) begin
                            opa_q   <= bus_in;
                            cc_q    <= cond_code_e'(cc_in);
                            state_q <= WAIT_B;
                        end else begin
                            con_q   <= taken_d;
                            state_q <= RESULT;
                        end
                    end
                end
                WAIT_B: begin
                    if (transfer) begin
                        con_q   <= taken_d;
                        state_q <= RESULT;
                    end
                end
                RESULT: begin
                    if (con_ack) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] eval_cnt_q;
    logic [STAT_W-1:0] taken_cnt_q;

    assign eval_cnt  = eval_cnt_q;
    assign taken_cnt = taken_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eval_cnt_q  <= '0;
            taken_cnt_q <= '0;
        end else if (eval_fire) begin
            if (eval_cnt_q != '1) begin
                eval_cnt_q <= eval_cnt_q + 1'b1;
            end
            if (taken_d && (taken_cnt_q != '1)) begin
                taken_cnt_q <= taken_cnt_q + 1'b1;
            end
        end
    end
`endif

endmodule
